clk_gate_manager: RTL

CLK_GATE_MANAGER -- requirements
Module: clk_gate_manager

---
 rtl/pm_pkg.sv | 7 +
 rtl/clk_gate_manager_channel.sv | 87 ++++++++
 rtl/clk_gate_manager.sv | 53 +++++
 3 files changed

// File: rtl/pm_pkg.sv
// pm_pkg: shared state encoding and default sizing for the clock-gate manager.
package pm_pkg;
    typedef enum logic [1:0] {OFF, WAKE, ON, IDLE} pm_state_e;
    localparam int PM_NUM_CH   = 4;
    localparam int PM_IDLE_W   = 8;
    localparam int PM_WAKE_CYC = 2;
endpackage

// File: rtl/clk_gate_manager_channel.sv
// pm_channel: one gated-clock channel FSM (OFF/WAKE/ON/IDLE) with wake and idle counters.
// Optional force-on override when PM_FORCE_ON_EN is defined.
module pm_channel
    import pm_pkg::*;
#(
    parameter int IDLE_W   = PM_IDLE_W,
    parameter int WAKE_CYC = PM_WAKE_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef PM_FORCE_ON_EN
    input  logic              force_on_i,
`endif
    input  logic              en_i,
    input  logic              act_i,
    input  logic [IDLE_W-1:0] thresh_i,
    output logic              clk_en_o,
    output logic              wake_done_o,
    output logic              wake_nxt_o,
    output logic              off_nxt_o
);
    pm_state_e         state_q, state_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [IDLE_W-1:0] icnt_q, icnt_d;
    logic              wd_q, wd_d;
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        icnt_d  = icnt_q;
        if (!en_i) begin
            state_d = OFF;
            wcnt_d  = '0;
            icnt_d  = '0;
        end else begin
            case (state_q)
                OFF: if (act_i) begin
                    state_d = WAKE;
                    wcnt_d  = 8'(WAKE_CYC - 1);
                end
                WAKE: begin
                    state_d = (wcnt_q == '0) ? ON : WAKE;
                    wcnt_d  = (wcnt_q == '0) ? '0 : wcnt_q - 8'd1;
                end
                ON: if (!act_i) begin
                    state_d = (thresh_i == '0) ? OFF : IDLE;
                    icnt_d  = (thresh_i == '0) ? '0 : IDLE_W'(1);
                end
                IDLE: if (act_i) begin
                    state_d = ON;
                    icnt_d  = '0;
                end else if (icnt_q >= thresh_i) begin
                    state_d = OFF;
                    icnt_d  = '0;
                end else begin
                    icnt_d  = icnt_q + IDLE_W'(icnt_q != '1);
                end
                default: state_d = OFF;
            endcase
        end
        wd_d = (state_q == WAKE) && (state_d == ON);
`ifdef PM_FORCE_ON_EN
        if (force_on_i) begin
            state_d = ON;
            wcnt_d  = '0;
            icnt_d  = '0;
            wd_d    = 1'b0;
        end
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            wcnt_q  <= '0;
            icnt_q  <= '0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            icnt_q  <= icnt_d;
            wd_q    <= wd_d;
        end
    end
    assign clk_en_o    = (state_q == ON) || (state_q == IDLE);
    assign wake_done_o = wd_q;
    assign wake_nxt_o  = state_d == WAKE;
    assign off_nxt_o   = state_d == OFF;
endmodule

// File: rtl/clk_gate_manager.sv
// clk_gate_manager: NUM_CH independent clock-gate channels plus registered busy/all-off summaries.
// Define PM_FORCE_ON_EN to add force_on_i, which drives every channel straight to ON.
module clk_gate_manager
    import pm_pkg::*;
#(
    parameter int NUM_CH   = PM_NUM_CH,
    parameter int IDLE_W   = PM_IDLE_W,
    parameter int WAKE_CYC = PM_WAKE_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef PM_FORCE_ON_EN
    input  logic                     force_on_i,
`endif
    input  logic [NUM_CH-1:0]        clk_en_i,
    input  logic [NUM_CH-1:0]        activity_i,
    input  logic [NUM_CH*IDLE_W-1:0] idle_thresh_i,
    output logic [NUM_CH-1:0]        clk_en_o,
    output logic [NUM_CH-1:0]        wake_done_o,
    output logic                     busy_o,
    output logic                     all_off_o
);
    logic [NUM_CH-1:0] wake_nxt, off_nxt;
    logic              busy_q, all_off_q;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pm_channel #(.IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
`ifdef PM_FORCE_ON_EN
            .force_on_i  (force_on_i),
`endif
            .en_i        (clk_en_i[g]),
            .act_i       (activity_i[g]),
            .thresh_i    (idle_thresh_i[g*IDLE_W +: IDLE_W]),
            .clk_en_o    (clk_en_o[g]),
            .wake_done_o (wake_done_o[g]),
            .wake_nxt_o  (wake_nxt[g]),
            .off_nxt_o   (off_nxt[g])
        );
    end
    // Reduced from next-state so the flags line up with the channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            all_off_q <= 1'b1;
        end else begin
            busy_q    <= |wake_nxt;
            all_off_q <= &off_nxt;
        end
    end
    assign busy_o    = busy_q;
    assign all_off_o = all_off_q;
endmodule
